// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types, defaults and helpers for the immediate extension arbiter
package imm_ext_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam int DEF_IN_W  = 21;
  localparam int DEF_OUT_W = 32;

  // Never returns less than 1 so an ID port always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/imm_sext.sv
// rtl/imm_sext.sv - combinational IN_W to OUT_W sign/zero extender
module imm_sext
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic             sgn_i,
  output logic [OUT_W-1:0] ext_o
);

  assign ext_o = {{(OUT_W-IN_W){sgn_i & imm_i[IN_W-1]}}, imm_i};

endmodule

// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - round-robin arbiter sharing one immediate extender, 1-cycle registered result
// Defining IMM_EXT_PERF_EN adds the saturating perf_stall_o backpressure cycle counter.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int NREQ  = 2,
  localparam int ID_W = clog2(NREQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*IN_W-1:0] req_imm_i,
  input  logic [NREQ-1:0]      req_sgn_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [OUT_W-1:0]     rsp_data_o,
  output logic [ID_W-1:0]      rsp_id_o
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [15:0]          perf_stall_o
`endif
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_last_q, rr_last_d;
  logic [ID_W-1:0]  gnt_idx, cand;
  logic             gnt_found, acc_en, hs;
  logic [IN_W-1:0]  sel_imm;
  logic             sel_sgn;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  // Scan starts just after the last winner, so the previous winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(rr_last_q) + k) % NREQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign acc_en = (state_q == IDLE) | ((state_q == RESP) & rsp_ready_i);
  assign hs     = acc_en & gnt_found;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx] = 1'b1;
  end

  assign sel_imm = req_imm_i[int'(gnt_idx)*IN_W +: IN_W];
  assign sel_sgn = req_sgn_i[gnt_idx];

  imm_sext #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sext (
    .imm_i (sel_imm),
    .sgn_i (sel_sgn),
    .ext_o (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (acc_en) state_d = hs ? RESP : IDLE;
    if (hs) begin
      rr_last_d  = gnt_idx;
      rsp_data_d = ext_data;
      rsp_id_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_last_q  <= ID_W'(NREQ - 1);
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

`ifdef IMM_EXT_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    if (rsp_valid_o && !rsp_ready_i && perf_stall_q != 16'hFFFF) perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_stall_q <= '0;
    else         perf_stall_q <= perf_stall_d;
  end

  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - directed self-checking bench for imm_ext_arbiter
module tb_imm_ext_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [41:0] req_imm;
  logic [1:0]  req_sgn;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;
`ifdef IMM_EXT_PERF_EN
  logic [15:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  imm_ext_arbiter #(.IN_W(21), .OUT_W(32), .NREQ(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_imm_i   (req_imm),
    .req_sgn_i   (req_sgn),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id)
`ifdef IMM_EXT_PERF_EN
    ,
    .perf_stall_o(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [20:0] i0, input logic s0,
                         input logic [20:0] i1, input logic s1);
    req_valid = v;
    req_imm   = {i1, i0};
    req_sgn   = {s1, s0};
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    set_req(2'b00, 21'h0, 1'b0, 21'h0, 1'b0);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Test 1: sign extension of req0
    rsp_ready = 1'b1;
    set_req(2'b01, 21'h100000, 1'b1, 21'h0, 1'b0);
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data", rsp_data, 32'hFFF00000);
    check("t1_id", 32'(rsp_id), 32'd0);

    // Test 2: req1 zero extension, then sign extension with a clear sign bit
    set_req(2'b10, 21'h0, 1'b0, 21'h100000, 1'b0);
    #1;
    check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    check("t2a_data", rsp_data, 32'h00100000);
    check("t2a_id", 32'(rsp_id), 32'd1);
    set_req(2'b10, 21'h0, 1'b0, 21'h0FFFFF, 1'b1);
    tick();
    check("t2b_data", rsp_data, 32'h000FFFFF);
    check("t2b_id", 32'(rsp_id), 32'd1);
    set_req(2'b00, 21'h0, 1'b0, 21'h0, 1'b0);
    tick();
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_hold", rsp_data, 32'h000FFFFF);

    // Test 3: both valid, alternating grants at full rate
    set_req(2'b11, 21'h000001, 1'b0, 21'h1FFFFF, 1'b1);
    for (int n = 0; n < 4; n++) begin
      #1;
      check("t3_ready", 32'(req_ready), (n % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check("t3_valid", 32'(rsp_valid), 32'd1);
      check("t3_id", 32'(rsp_id), (n % 2 == 0) ? 32'd0 : 32'd1);
      check("t3_data", rsp_data, (n % 2 == 0) ? 32'h00000001 : 32'hFFFFFFFF);
    end

    // Test 4: backpressure for three cycles
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("t4_ready", 32'(req_ready), 32'd0);
      tick();
      check("t4_valid", 32'(rsp_valid), 32'd1);
      check("t4_id", 32'(rsp_id), 32'd1);
      check("t4_data", rsp_data, 32'hFFFFFFFF);
    end
`ifdef IMM_EXT_PERF_EN
    check("t4_perf", 32'(perf_stall), 32'd3);
`endif
    rsp_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(req_ready), 32'h1);
    tick();
    check("t4_release_id", 32'(rsp_id), 32'd0);
    check("t4_release_data", rsp_data, 32'h00000001);

    // Test 5: asynchronous reset while a result is pending
    set_req(2'b00, 21'h0, 1'b0, 21'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(rsp_valid), 32'd0);
    check("t5_data", rsp_data, 32'h0);
    check("t5_id", 32'(rsp_id), 32'd0);
    #1;
    rst_n = 1'b1;
    set_req(2'b10, 21'h000001, 1'b0, 21'h1FFFFF, 1'b1);
    #1;
    check("t5_req1_ready", 32'(req_ready), 32'h2);
    tick();
    check("t5_req1_id", 32'(rsp_id), 32'd1);
    check("t5_req1_data", rsp_data, 32'hFFFFFFFF);
    set_req(2'b11, 21'h000001, 1'b0, 21'h1FFFFF, 1'b1);
    #1;
    check("t5_tie_ready", 32'(req_ready), 32'h1);
    tick();
    check("t5_tie_id", 32'(rsp_id), 32'd0);

    // Test 6: accept on the same edge as consumption, no bubble
    set_req(2'b01, 21'h0AAAAA, 1'b1, 21'h0, 1'b0);
    tick();
    check("t6_valid", 32'(rsp_valid), 32'd1);
    check("t6_data", rsp_data, 32'h000AAAAA);
    check("t6_id", 32'(rsp_id), 32'd0);
    set_req(2'b00, 21'h0, 1'b0, 21'h0, 1'b0);
    tick();
    check("t6_drain", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
